power_alu_seq: RTL and testbench

Parametrised, handshaked successor to the 8-bit PowerALU accumulator. The registered result b acts as the accumulator and is also operand B. The block adds:
- a configurable data width
- a wrap or saturate arithmetic mode
- registered status flags
- a valid/ready input handshake
- an iterative multi-cycle signed multiply

It sits between the sequencer issuing opcodes and the datapath consuming b.

---
 rtl/power_alu_pkg.sv | 38 +++
 rtl/power_alu_if.sv | 29 ++
 rtl/power_alu_mul_seq.sv | 81 ++++++++
 rtl/power_alu_seq.sv | 194 +++++++++++++++++++
 tb/tb_power_alu_seq.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/power_alu_pkg.sv
// power_alu_pkg
//   Shared definitions for the power_alu_seq accumulator ALU:
//   - opcode encodings (OP_TRA..OP_CLR)
//   - flag bit positions inside the 4-bit {n, z, v, c} flag word
//   - reset value of the flag word
//   - control FSM state encoding
package power_alu_pkg;

  typedef enum logic [3:0] {
    OP_TRA = 4'd0,
    OP_INC = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_DEC = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_NEG = 4'd8,
    OP_SHL = 4'd9,
    OP_ASR = 4'd10,
    OP_MUL = 4'd11,
    OP_CLR = 4'd12
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // b resets to zero, so only z is set
  localparam logic [3:0] FLAGS_RESET = 4'b0100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/power_alu_if.sv
// power_alu_if
//   Opcode/operand handshake and result bus between the sequencer (master)
//   and the ALU (slave).
//   in_valid, opcode, a : sequencer -> ALU, request with operand A
//   in_ready            : ALU -> sequencer, request accepted when both high
//   b, flags            : ALU -> datapath, accumulator and {n, z, v, c}
//   busy, done          : ALU -> sequencer, multiply in progress / result pulse
interface power_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       flags;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, opcode, a,
    input  in_ready, b, flags, busy, done
  );

  modport slave (
    input  in_valid, opcode, a,
    output in_ready, b, flags, busy, done
  );
endinterface

// File: rtl/power_alu_mul_seq.sv
// power_alu_mul_seq
//   Iterative signed multiplier: shift-add over operand magnitudes, one
//   partial product per clock, sign restored on the output.
//   clk, rst_n : clock, asynchronous active-low reset (aborts a multiply)
//   start_i    : latch a_i/b_i and begin; first partial product taken here
//   a_i, b_i   : signed WIDTH-bit operands
//   done_o     : high for the one cycle in which product_o/ovf_o are final
//   product_o  : signed 2*WIDTH-bit product
//   ovf_o      : product does not fit in WIDTH signed bits
module power_alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o,
  output logic               ovf_o
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Magnitude of a two's-complement value; the most negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  logic               run_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               neg_q;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH:0]     top_bits_s;

  assign mag_a_s = mag(a_i);
  assign mag_b_s = mag(b_i);

  // Shift-add datapath: start does step 0, then WIDTH-1 further steps, so the
  // product is final WIDTH-1 edges after start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      p_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      cnt_q    <= CNT_INIT;
      p_q      <= mag_a_s[0] ? {{WIDTH{1'b0}}, mag_b_s} : '0;
      mcand_q  <= {{(WIDTH-1){1'b0}}, mag_b_s, 1'b0};
      mplier_q <= {1'b0, mag_a_s[WIDTH-1:1]};
      neg_q    <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        p_q      <= p_q + (mplier_q[0] ? mcand_q : '0);
        mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
        cnt_q    <= cnt_q - CNT_ONE;
      end
    end
  end

  assign done_o     = run_q && (cnt_q == '0);
  assign product_o  = neg_q ? (~p_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : p_q;
  // Fits in WIDTH signed bits only if the top WIDTH+1 bits are all equal
  assign top_bits_s = product_o[2*WIDTH-1:WIDTH-1];
  assign ovf_o      = !((&top_bits_s) || !(|top_bits_s));

endmodule

// File: rtl/power_alu_seq.sv
// power_alu_seq
//   Handshaked accumulator ALU. The registered result b is also operand B.
//   Single-cycle ops write b/flags at the accepting edge; MUL runs on the
//   iterative multiplier and writes WIDTH edges after accept.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : power_alu_if slave (in_valid/in_ready/opcode/a in,
//                b/flags/busy/done out)
//   SAT        : 0 = two's-complement wrap, 1 = clamp on signed overflow
module power_alu_seq
  import power_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SAT   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  power_alu_if.slave  bus
);

  localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

  // Clamp value in the direction of the true result's sign
  function automatic logic [WIDTH-1:0] sat_clamp(input logic neg);
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  state_e             state_q;
  logic [WIDTH-1:0]   b_q;
  logic [3:0]         flags_q;
  logic               busy_q;
  logic               ready_q;
  logic               done_q;

  op_e                op_s;
  logic               accept_s;
  logic               mul_start_s;
  logic [WIDTH:0]     a_x_s;
  logic [WIDTH:0]     b_x_s;
  logic [WIDTH:0]     wide_s;
  logic [WIDTH-1:0]   raw_s;
  logic               arith_s;
  logic               keep_s;
  logic               v_s;
  logic               c_s;
  logic [WIDTH-1:0]   alu_res_d;
  logic [3:0]         alu_flags_d;

  logic               mul_done_s;
  logic               mul_ovf_s;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic [WIDTH-1:0]   mul_res_d;
  logic [3:0]         mul_flags_d;

  assign op_s        = op_e'(bus.opcode);
  assign accept_s    = bus.in_valid && ready_q;
  assign mul_start_s = accept_s && (state_q == ST_IDLE) && (op_s == OP_MUL);
  assign a_x_s       = {bus.a[WIDTH-1], bus.a};
  assign b_x_s       = {b_q[WIDTH-1], b_q};

  power_alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start_s),
    .a_i       (bus.a),
    .b_i       (b_q),
    .done_o    (mul_done_s),
    .product_o (mul_prod_s),
    .ovf_o     (mul_ovf_s)
  );

  // Single-cycle result: arithmetic ops evaluated at WIDTH+1 bits so that
  // bit WIDTH carries the true sign for overflow detection and clamping.
  always_comb begin
    wide_s      = '0;
    raw_s       = b_q;
    arith_s     = 1'b0;
    keep_s      = 1'b0;
    c_s         = 1'b0;
    alu_flags_d = flags_q;
    case (op_s)
      OP_TRA: raw_s = bus.a;
      OP_INC: begin
        wide_s  = a_x_s + ONE_X;
        arith_s = 1'b1;
        c_s     = &bus.a;
      end
      OP_ADD: begin
        wide_s  = a_x_s + b_x_s;
        arith_s = 1'b1;
        // unsigned carry out of the WIDTH-bit add
        c_s     = (bus.a[WIDTH-1] & b_q[WIDTH-1]) |
                  ((bus.a[WIDTH-1] | b_q[WIDTH-1]) & ~wide_s[WIDTH-1]);
      end
      OP_SUB: begin
        wide_s  = a_x_s - b_x_s;
        arith_s = 1'b1;
        c_s     = bus.a < b_q;
      end
      OP_DEC: begin
        wide_s  = a_x_s - ONE_X;
        arith_s = 1'b1;
        c_s     = bus.a == '0;
      end
      OP_AND: raw_s = bus.a & b_q;
      OP_OR:  raw_s = bus.a | b_q;
      OP_XOR: raw_s = bus.a ^ b_q;
      OP_NEG: begin
        wide_s  = ~a_x_s + ONE_X;
        arith_s = 1'b1;
      end
      OP_SHL: begin
        wide_s  = {bus.a, 1'b0};
        arith_s = 1'b1;
        c_s     = bus.a[WIDTH-1];
      end
      OP_ASR: raw_s = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
      OP_CLR: raw_s = '0;
      OP_MUL: keep_s = 1'b1;
      default: keep_s = 1'b1;
    endcase
    v_s = arith_s && (wide_s[WIDTH] != wide_s[WIDTH-1]);
    if (arith_s) begin
      alu_res_d = ((SAT != 0) && v_s) ? sat_clamp(wide_s[WIDTH]) : wide_s[WIDTH-1:0];
    end else begin
      alu_res_d = raw_s;
    end
    if (!keep_s) begin
      alu_flags_d[FLAG_N] = alu_res_d[WIDTH-1];
      alu_flags_d[FLAG_Z] = (alu_res_d == '0);
      alu_flags_d[FLAG_V] = v_s;
      alu_flags_d[FLAG_C] = c_s;
    end else begin
      alu_flags_d = flags_q;
    end
  end

  // Multiply result: wrap keeps the low half, saturation clamps on overflow
  always_comb begin
    mul_res_d   = ((SAT != 0) && mul_ovf_s) ? sat_clamp(mul_prod_s[2*WIDTH-1])
                                            : mul_prod_s[WIDTH-1:0];
    mul_flags_d = {mul_res_d[WIDTH-1], (mul_res_d == '0), mul_ovf_s, 1'b0};
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      flags_q <= FLAGS_RESET;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            if (op_s == OP_MUL) begin
              state_q <= ST_MUL;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              b_q     <= alu_res_d;
              flags_q <= alu_flags_d;
              done_q  <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_done_s) begin
            b_q     <= mul_res_d;
            flags_q <= mul_flags_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.b        = b_q;
  assign bus.flags    = flags_q;
  assign bus.busy     = busy_q;
  assign bus.in_ready = ready_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_power_alu_seq.sv
// tb_power_alu_seq
//   Drives identical directed stimulus into a wrap (SAT=0) and a saturating
//   (SAT=1) instance. Expected results go into one queue per instance; a
//   monitor pops and compares on every done pulse.
module tb_power_alu_seq;
  import power_alu_pkg::*;

  typedef struct {
    string      name;
    logic [7:0] b;
    logic [3:0] f;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t qw[$];
  exp_t qs[$];

  power_alu_if #(.WIDTH(8)) if_w ();
  power_alu_if #(.WIDTH(8)) if_s ();

  power_alu_seq #(.WIDTH(8), .SAT(0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(if_w));
  power_alu_seq #(.WIDTH(8), .SAT(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [7:0] bw, input logic [3:0] fw,
                      input logic [7:0] bs, input logic [3:0] fs);
    exp_t e;
    e.name = name; e.b = bw; e.f = fw;
    qw.push_back(e);
    e.b = bs; e.f = fs;
    qs.push_back(e);
  endtask

  // drive a request into both instances without waiting; held for one edge
  task automatic drive_op(input logic [3:0] op, input logic [7:0] a);
    if_w.in_valid = 1'b1; if_w.opcode = op; if_w.a = a;
    if_s.in_valid = 1'b1; if_s.opcode = op; if_s.a = a;
    @(posedge clk);
    #1;
    if_w.in_valid = 1'b0;
    if_s.in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a);
    @(negedge clk);
    drive_op(op, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_both_state(input string name, input logic [7:0] b, input logic [3:0] f,
                                input logic busy, input logic rdy, input logic done);
    chk({name, " b_w"}, 32'(if_w.b), 32'(b));
    chk({name, " f_w"}, 32'(if_w.flags), 32'(f));
    chk({name, " busy_w"}, 32'(if_w.busy), 32'(busy));
    chk({name, " rdy_w"}, 32'(if_w.in_ready), 32'(rdy));
    chk({name, " done_w"}, 32'(if_w.done), 32'(done));
    chk({name, " b_s"}, 32'(if_s.b), 32'(b));
    chk({name, " f_s"}, 32'(if_s.flags), 32'(f));
    chk({name, " busy_s"}, 32'(if_s.busy), 32'(busy));
    chk({name, " rdy_s"}, 32'(if_s.in_ready), 32'(rdy));
    chk({name, " done_s"}, 32'(if_s.done), 32'(done));
  endtask

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    exp_t e;
    if (if_w.done) begin
      checks++;
      if (qw.size() == 0) begin
        failures++;
        $display("FAIL wrap unexpected done: b=%0h flags=%0h", if_w.b, if_w.flags);
      end else begin
        e = qw.pop_front();
        chk({e.name, " wrap b"}, 32'(if_w.b), 32'(e.b));
        chk({e.name, " wrap flags"}, 32'(if_w.flags), 32'(e.f));
      end
    end
    if (if_s.done) begin
      checks++;
      if (qs.size() == 0) begin
        failures++;
        $display("FAIL sat unexpected done: b=%0h flags=%0h", if_s.b, if_s.flags);
      end else begin
        e = qs.pop_front();
        chk({e.name, " sat b"}, 32'(if_s.b), 32'(e.b));
        chk({e.name, " sat flags"}, 32'(if_s.flags), 32'(e.f));
      end
    end
  end

  initial begin
    int n;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    if_w.in_valid = 1'b0; if_w.opcode = 4'd0; if_w.a = 8'd0;
    if_s.in_valid = 1'b0; if_s.opcode = 4'd0; if_s.a = 8'd0;
    idle(3);
    chk_both_state("reset", 8'h00, 4'b0100, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;

    // 1. transfer, reset mid-run, transfer again
    push("TRA 33", 8'd33, 4'b0000, 8'd33, 4'b0000);
    send(OP_TRA, 8'd33);
    idle(2);
    rst_n = 1'b0;
    #1;
    chk_both_state("midrun reset", 8'h00, 4'b0100, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    push("TRA 10", 8'd10, 4'b0000, 8'd10, 4'b0000);
    send(OP_TRA, 8'd10);
    @(negedge clk);
    chk("TRA done pulse", 32'(if_w.done), 32'd1);
    @(negedge clk);
    chk("TRA done single", 32'(if_w.done), 32'd0);
    push("TRA -15", 8'hF1, 4'b1000, 8'hF1, 4'b1000);
    send(OP_TRA, 8'hF1);

    // 2. increment overflow
    push("INC 127", 8'h80, 4'b1010, 8'h7F, 4'b0010);
    send(OP_INC, 8'h7F);

    // 3. add/sub chain, back-to-back accepts
    push("TRA 20", 8'd20, 4'b0000, 8'd20, 4'b0000);
    send(OP_TRA, 8'd20);
    push("ADD -15", 8'd5, 4'b0001, 8'd5, 4'b0001);
    drive_op(OP_ADD, 8'hF1);
    push("SUB 10", 8'd5, 4'b0000, 8'd5, 4'b0000);
    drive_op(OP_SUB, 8'd10);
    push("SUB 5", 8'd0, 4'b0100, 8'd0, 4'b0100);
    drive_op(OP_SUB, 8'd5);

    // boundary ops
    push("NEG -128", 8'h80, 4'b1010, 8'h7F, 4'b0010);
    send(OP_NEG, 8'h80);
    push("DEC 0", 8'hFF, 4'b1001, 8'hFF, 4'b1001);
    send(OP_DEC, 8'h00);
    push("SHL C0", 8'h80, 4'b1001, 8'h80, 4'b1001);
    send(OP_SHL, 8'hC0);
    push("ASR 81", 8'hC0, 4'b1000, 8'hC0, 4'b1000);
    send(OP_ASR, 8'h81);
    push("XOR 0F", 8'hCF, 4'b1000, 8'hCF, 4'b1000);
    send(OP_XOR, 8'h0F);
    push("NOP 13", 8'hCF, 4'b1000, 8'hCF, 4'b1000);
    send(4'd13, 8'h55);
    push("CLR", 8'h00, 4'b0100, 8'h00, 4'b0100);
    send(OP_CLR, 8'h33);

    // 4. multiply with overflow; a request during busy is ignored
    push("TRA -12", 8'hF4, 4'b1000, 8'hF4, 4'b1000);
    send(OP_TRA, 8'hF4);
    push("MUL 11", 8'h7C, 4'b0010, 8'h80, 4'b1010);
    send(OP_MUL, 8'd11);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("MUL busy", 32'(if_w.busy), 32'd1);
      chk("MUL in_ready", 32'(if_s.in_ready), 32'd0);
      chk("MUL no early done", 32'(if_w.done), 32'd0);
      if (i == 2) begin
        if_w.in_valid = 1'b1; if_w.opcode = OP_TRA; if_w.a = 8'd99;
        if_s.in_valid = 1'b1; if_s.opcode = OP_TRA; if_s.a = 8'd99;
      end
      if (i == 4) begin
        if_w.in_valid = 1'b0;
        if_s.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("MUL done at 9", 32'(if_w.done), 32'd1);
    chk("MUL busy fall", 32'(if_s.busy), 32'd0);
    idle(2);
    chk("ignored TRA b_w", 32'(if_w.b), 32'h7C);
    chk("ignored TRA b_s", 32'(if_s.b), 32'h80);

    // 5. multiply in range, latency measured with a bound
    push("TRA -5", 8'hFB, 4'b1000, 8'hFB, 4'b1000);
    send(OP_TRA, 8'hFB);
    push("MUL 6", 8'hE2, 4'b1000, 8'hE2, 4'b1000);
    send(OP_MUL, 8'd6);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_w.done && n < 20);
    chk("MUL latency", 32'(n), 32'd9);

    // 6. reset three cycles into a multiply, then immediate transfer
    push("TRA 3", 8'd3, 4'b0000, 8'd3, 4'b0000);
    send(OP_TRA, 8'd3);
    send(OP_MUL, 8'd5);
    idle(3);
    rst_n = 1'b0;
    #1;
    chk_both_state("reset in MUL", 8'h00, 4'b0100, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    push("TRA 7", 8'd7, 4'b0000, 8'd7, 4'b0000);
    drive_op(OP_TRA, 8'd7);
    idle(12);
    chk_both_state("after abort", 8'd7, 4'b0000, 1'b0, 1'b1, 1'b0);

    chk("queue drained wrap", 32'(qw.size()), 32'd0);
    chk("queue drained sat", 32'(qs.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
